// File: rtl/cfa_weighted_normalizer.sv
// rtl/cfa_weighted_normalizer.sv - window accumulator with power-of-two normalisation, rounding and 8-bit clamp
//
// Purpose: sums one interpolation window of signed pixel*weight products and
//          emits (sum + 2^(SHIFT-1)) >>> SHIFT, clamped to [0, 2^OUT_W-1].
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   product beat handshake; in_prod signed, in_last ends window
//   out_valid/out_ready pixel handshake; out_pix clamped pixel
//   out_sat             result was clamped
//   out_trunc           window was closed at MAX_TERMS beats without in_last
module cfa_weighted_normalizer #(
    parameter int PROD_W    = 21,
    parameter int MAX_TERMS = 16,
    parameter int ACC_W     = 25,
    parameter int SHIFT     = 7,
    parameter int OUT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_pix,
    output logic              out_sat,
    output logic              out_trunc
);

    localparam int CNT_W = $clog2(MAX_TERMS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_TERMS - 1);
    // One extra bit so adding the rounding constant can never wrap.
    localparam logic signed [ACC_W:0] ROUND_K = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_W:0] PIX_MAX = {{(ACC_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_NORM  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic signed [ACC_W-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0]        cnt_q,       cnt_d;
    logic                    trunc_q,     trunc_d;
    logic                    out_valid_q, out_valid_d;
    logic [OUT_W-1:0]        out_pix_q,   out_pix_d;
    logic                    out_sat_q,   out_sat_d;
    logic                    out_trunc_q, out_trunc_d;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W:0]   rounded;
    logic signed [ACC_W:0]   r_full;

    assign prod_ext = {{(ACC_W - PROD_W){in_prod[PROD_W-1]}}, in_prod};
    assign rounded  = {acc_q[ACC_W-1], acc_q} + ROUND_K;
    assign r_full   = rounded >>> SHIFT;

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = out_valid_q;
    assign out_pix   = out_pix_q;
    assign out_sat   = out_sat_q;
    assign out_trunc = out_trunc_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        trunc_d     = trunc_q;
        out_valid_d = out_valid_q;
        out_pix_d   = out_pix_q;
        out_sat_d   = out_sat_q;
        out_trunc_d = out_trunc_q;
        case (state_q)
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (in_last || (cnt_q == CNT_LAST)) begin
                        state_d = ST_NORM;
                        // Reaching this branch without in_last means the count forced the close.
                        trunc_d = !in_last;
                    end
                end
            end
            ST_NORM: begin
                if (r_full < 0) begin
                    out_pix_d = '0;
                    out_sat_d = 1'b1;
                end else if (r_full > PIX_MAX) begin
                    out_pix_d = {OUT_W{1'b1}};
                    out_sat_d = 1'b1;
                end else begin
                    out_pix_d = r_full[OUT_W-1:0];
                    out_sat_d = 1'b0;
                end
                out_trunc_d = trunc_q;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    trunc_d     = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            trunc_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            out_sat_q   <= 1'b0;
            out_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            trunc_q     <= trunc_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
            out_sat_q   <= out_sat_d;
            out_trunc_q <= out_trunc_d;
        end
    end

endmodule
